store_rmw_unit: RTL and testbench

- Store-side data narrowing path for the MIPS datapath: the inverse of load-side sign/zero extension.
- Takes a 32-bit register value plus a store size (SB/SH/SW) and writes only the addressed byte or halfword into a word-wide data memory with no byte enables.
- Sub-word stores use a read-modify-write sequence; word stores write directly.
- Sits between the MEM-stage control and the data memory; stalls the core via req_ready and busy.

---
 rtl/store_rmw_unit.sv | 195 +++++++++++++++++++
 tb/tb_store_rmw_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - store narrowing: SB/SH via read-modify-write, SW direct.
// Define STORE_MEM_BE_EN for byte-enabled memories: every size writes directly with a mem_be lane mask.
module store_rmw_unit #(
  parameter int ADDR_W     = 10,
  parameter int READ_LAT   = 1,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err_misaligned,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
`ifdef STORE_MEM_BE_EN
  ,
  output logic [3:0]        mem_be
`endif
);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
`ifdef STORE_MEM_BE_EN
  localparam bit DIRECT_ALL = 1'b1;
`else
  localparam bit DIRECT_ALL = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [1:0]        cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic              legal_d;
  logic [1:0]        lane_d;
  logic              unused_addr_bits;
`ifdef STORE_MEM_BE_EN
  logic [3:0]        be_q;
  logic [3:0]        be_d;
`endif

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Lane is the lowest byte lane touched; big-endian mirrors it within the word.
  always_comb begin
    legal_d = 1'b0;
    case (req_size)
      SZ_B:    legal_d = 1'b1;
      SZ_H:    legal_d = ~req_addr[0];
      SZ_W:    legal_d = (req_addr[1:0] == 2'b00);
      default: legal_d = 1'b0;
    endcase
    if (!BIG_ENDIAN)
      lane_d = req_addr[1:0];
    else if (req_size == SZ_B)
      lane_d = 2'd3 - req_addr[1:0];
    else
      lane_d = 2'd2 - req_addr[1:0];
  end

`ifdef STORE_MEM_BE_EN
  always_comb begin
    case (req_size)
      SZ_B:    be_d = 4'b0001 << lane_d;
      SZ_H:    be_d = 4'b0011 << lane_d;
      default: be_d = 4'b1111;
    endcase
  end
`endif

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] val,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] mask;
    mask = (size == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (old_w & ~(mask << {lane, 3'b000})) | ((val & mask) << {lane, 3'b000});
  endfunction

  function automatic logic [31:0] direct_data(input logic [31:0] val, input logic [1:0] size);
    if (!DIRECT_ALL || size == SZ_W) return val;
    if (size == SZ_B) return {4{val[7:0]}};
    return {2{val[15:0]}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef STORE_MEM_BE_EN
      be_q    <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
`ifdef STORE_MEM_BE_EN
      be_q    <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (!legal_d) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= req_addr[ADDR_W+1:2];
              data_q  <= req_data;
              size_q  <= req_size;
              lane_q  <= lane_d;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              if (req_size == SZ_W || DIRECT_ALL) begin
                state_q <= S_WR;
                wr_en_q <= 1'b1;
                wdata_q <= direct_data(req_data, req_size);
`ifdef STORE_MEM_BE_EN
                be_q    <= be_d;
`endif
              end else begin
                state_q <= S_RD;
                rd_en_q <= 1'b1;
              end
            end
          end
        end
        S_RD: begin
          state_q <= S_WAIT;
          cnt_q   <= 2'(READ_LAT - 1);
        end
        // mem_rdata is valid on the edge READ_LAT cycles after the memory saw mem_rd_en.
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= S_WR;
            wr_en_q <= 1'b1;
            wdata_q <= merge(mem_rdata, data_q, size_q, lane_q);
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_WR: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          wdata_q <= '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_misaligned = err_q;
  assign mem_addr       = addr_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_wdata      = wdata_q;
`ifdef STORE_MEM_BE_EN
  assign mem_be         = be_q;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb/tb_store_rmw_unit.sv - bench for store_rmw_unit: three configs (LE/lat1, BE/lat1, LE/lat3) in lockstep.
module tb_store_rmw_unit;
  localparam int LAT [3] = '{1, 1, 3};
  localparam bit BIG [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic [31:0] mem_word;

  logic        rdy[3], bsy[3], rd[3], wr[3], dn[3], er[3];
  logic [9:0]  ma[3];
  logic [31:0] rdat[3], wd[3];
`ifdef STORE_MEM_BE_EN
  logic [3:0]  be[3];
  logic [3:0]  last_be[3];
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(10), .READ_LAT(1), .BIG_ENDIAN(1'b0)) u_le1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .done(dn[0]), .err_misaligned(er[0]), .busy(bsy[0]),
    .mem_addr(ma[0]), .mem_rd_en(rd[0]), .mem_rdata(rdat[0]), .mem_wr_en(wr[0]), .mem_wdata(wd[0])
`ifdef STORE_MEM_BE_EN
    , .mem_be(be[0])
`endif
  );
  store_rmw_unit #(.ADDR_W(10), .READ_LAT(1), .BIG_ENDIAN(1'b1)) u_be1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .done(dn[1]), .err_misaligned(er[1]), .busy(bsy[1]),
    .mem_addr(ma[1]), .mem_rd_en(rd[1]), .mem_rdata(rdat[1]), .mem_wr_en(wr[1]), .mem_wdata(wd[1])
`ifdef STORE_MEM_BE_EN
    , .mem_be(be[1])
`endif
  );
  store_rmw_unit #(.ADDR_W(10), .READ_LAT(3), .BIG_ENDIAN(1'b0)) u_le3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .done(dn[2]), .err_misaligned(er[2]), .busy(bsy[2]),
    .mem_addr(ma[2]), .mem_rd_en(rd[2]), .mem_rdata(rdat[2]), .mem_wr_en(wr[2]), .mem_wdata(wd[2])
`ifdef STORE_MEM_BE_EN
    , .mem_be(be[2])
`endif
  );

  // Memory: read data is valid only in the single cycle READ_LAT after the strobe, junk otherwise.
  int          rd_age[3], rd_cnt[3], wr_cnt[3];
  bit          rd_pend[3];
  logic [31:0] last_wr[3];
  logic [9:0]  rd_addr[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) rd_pend[i] = 1'b0;
      else if (rd[i]) begin
        rd_pend[i] = 1'b1; rd_age[i] = 0; rd_cnt[i]++; rd_addr[i] = ma[i];
      end else if (rd_pend[i]) rd_age[i]++;
      rdat[i] = (rd_pend[i] && rd_age[i] == LAT[i]) ? mem_word : 32'h5A5A_5A5A;
      if (wr[i]) begin
        wr_cnt[i]++; last_wr[i] = wd[i]; rd_pend[i] = 1'b0;
`ifdef STORE_MEM_BE_EN
        last_be[i] = be[i];
`endif
      end
    end
  end

  // Transaction model: age = cycles since accept; kind 1 = error, 2 = direct write, 3 = sub-word.
  int          age = 0;
  int          m_kind = 0;
  logic [31:0] m_addr, m_data, m_word;
  logic [1:0]  m_size;
  logic        v_s;
  int          done_age[3];

  function automatic int len(input int i);
    if (m_kind == 1) return 1;
    if (m_kind == 2) return 2;
`ifdef STORE_MEM_BE_EN
    return 2;
`else
    return LAT[i] + 3;
`endif
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++)
      if (!(age == 0 || age > len(i))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int classify(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)) return 1;
    if (s == 2'b10) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_wdata(input int i);
    logic [7:0] b[4];
    int a;
    a = int'(m_addr[1:0]);
    if (m_kind == 2) return m_data;
`ifdef STORE_MEM_BE_EN
    if (m_size == 2'b00) return {4{m_data[7:0]}};
    return {2{m_data[15:0]}};
`else
    for (int k = 0; k < 4; k++) b[k] = m_word[8*k +: 8];
    if (m_size == 2'b00) b[BIG[i] ? 3 - a : a] = m_data[7:0];
    else if (BIG[i]) begin b[3 - a] = m_data[15:8]; b[2 - a] = m_data[7:0]; end
    else begin b[a] = m_data[7:0]; b[a + 1] = m_data[15:8]; end
    return {b[3], b[2], b[1], b[0]};
`endif
  endfunction

  function automatic logic [3:0] exp_be(input int i);
    logic [3:0] m;
    int a;
    a = int'(m_addr[1:0]);
    m = 4'b0000;
    if (m_kind == 2) m = 4'b1111;
    else if (m_size == 2'b00) m[BIG[i] ? 3 - a : a] = 1'b1;
    else if (BIG[i]) begin m[3 - a] = 1'b1; m[2 - a] = 1'b1; end
    else begin m[a] = 1'b1; m[a + 1] = 1'b1; end
    return m;
  endfunction

  task automatic check_dut(input int i);
    logic [5:0]  e_ctl, a_ctl;
    logic [31:0] e_wd;
    bit          e_rdy, e_bsy, e_rd, e_wr, e_dn, e_er, ok;
    e_rdy = 1; e_bsy = 0; e_rd = 0; e_wr = 0; e_dn = 0; e_er = 0;
    if (age > 0 && age <= len(i)) begin
      if (m_kind == 1) e_er = 1;
      else begin
        e_rdy = 0; e_bsy = 1;
`ifndef STORE_MEM_BE_EN
        if (m_kind == 3) begin
          e_rd = (age == 1); e_wr = (age == LAT[i] + 2); e_dn = (age == LAT[i] + 3);
        end else
`endif
        begin
          e_wr = (age == 1); e_dn = (age == 2);
        end
      end
    end
    e_ctl = {e_rdy, e_bsy, e_rd, e_wr, e_dn, e_er};
    a_ctl = {rdy[i], bsy[i], rd[i], wr[i], dn[i], er[i]};
    e_wd  = exp_wdata(i);
    ok = (a_ctl == e_ctl) && (!e_wr || wd[i] == e_wd) && (!e_bsy || ma[i] == m_addr[11:2]);
`ifdef STORE_MEM_BE_EN
    ok = ok && (be[i] == (e_wr ? exp_be(i) : 4'b0000));
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL cycle dut%0d age%0d: got ctl=%b wd=%h ma=%h, want ctl=%b wd=%h ma=%h",
               i, age, a_ctl, wd[i], ma[i], e_ctl, e_wd, m_addr[11:2]);
    end
    if (dn[i]) done_age[i] = age;
  endtask

  always @(posedge clk) begin
    v_s = req_valid;
    #1;
    if (!rst_n) age = 0;
    else if (v_s && all_idle()) begin
      age = 1; m_addr = req_addr; m_data = req_data; m_size = req_size; m_word = mem_word;
      m_kind = classify(req_addr, req_size);
    end else if (age > 0 && age < 1000) age++;
    for (int i = 0; i < 3; i++) check_dut(i);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  task automatic rst_chk(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk(nm, {26'd0, rdy[i], bsy[i], rd[i], wr[i], dn[i], er[i]}, 32'h0000_0020);
      chk(nm, {22'd0, ma[i]}, 32'd0);
      chk(nm, wd[i], 32'd0);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] w, input int hold);
    @(negedge clk);
    for (int i = 0; i < 3; i++) done_age[i] = 0;
    mem_word = w; req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    repeat (hold) @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  localparam int NV = 5;
  logic [31:0] t_addr [NV] = '{32'h0, 32'h2, 32'h0, 32'h102, 32'h3FC};
  logic [31:0] t_data [NV] = '{32'h55, 32'h77, 32'hBEEF, 32'hA5A5, 32'h1357_9BDF};
  logic [1:0]  t_size [NV] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
  logic [31:0] t_word [NV] = '{32'h0102_0304, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h0};

  int rc[3], wc[3];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_word = '0;
    repeat (3) @(negedge clk);
    rst_chk("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // SB addr 0x41 into 0x11223344
    for (int i = 0; i < 3; i++) begin rc[i] = rd_cnt[i]; wc[i] = wr_cnt[i]; end
    issue(32'h41, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 1);
`ifdef STORE_MEM_BE_EN
    chk("sb_wdata", last_wr[0], 32'hABAB_ABAB);
    chk("sb_be", {28'd0, last_be[0]}, 32'h2);
    chk("sb_done_lat", done_age[0], 2);
    chk("sb_no_read", rd_cnt[0] - rc[0], 0);
`else
    chk("sb_wdata", last_wr[0], 32'h1122_AB44);
    chk("sb_done_lat", done_age[0], 4);
    chk("sb_rd_count", rd_cnt[0] - rc[0], 1);
    chk("sb_rd_addr", {22'd0, rd_addr[0]}, 32'h10);
`endif
    chk("sb_wr_count", wr_cnt[0] - wc[0], 1);

    // SH addr 0x2 into 0xAABBCCDD, big-endian instance
    issue(32'h2, 32'h1234, 2'b01, 32'hAABB_CCDD, 1);
`ifdef STORE_MEM_BE_EN
    chk("sh_be_wdata", last_wr[1], 32'h1234_1234);
    chk("sh_be_mask", {28'd0, last_be[1]}, 32'h3);
`else
    chk("sh_be_wdata", last_wr[1], 32'hAABB_1234);
    chk("sh_le_wdata", last_wr[0], 32'h1234_CCDD);
`endif

    // SW addr 0x8
    for (int i = 0; i < 3; i++) rc[i] = rd_cnt[i];
    issue(32'h8, 32'hDEAD_BEEF, 2'b10, 32'h0, 1);
    chk("sw_wdata", last_wr[0], 32'hDEAD_BEEF);
    chk("sw_done_lat", done_age[0], 2);
    chk("sw_no_read", rd_cnt[0] - rc[0], 0);

    // misaligned half, misaligned word, reserved size
    for (int i = 0; i < 3; i++) begin rc[i] = rd_cnt[i]; wc[i] = wr_cnt[i]; end
    issue(32'h3, 32'h1111, 2'b01, 32'h0, 1);
    issue(32'h6, 32'h2222, 2'b10, 32'h0, 1);
    issue(32'h0, 32'h3333, 2'b11, 32'h0, 1);
    for (int i = 0; i < 3; i++) chk("err_no_strobe", (rd_cnt[i] - rc[i]) + (wr_cnt[i] - wc[i]), 0);

    // SB addr 0x3: lat3 instance must sample read data exactly 3 cycles after the strobe
    issue(32'h3, 32'h0000_00AB, 2'b00, 32'h1122_3344, 1);
`ifdef STORE_MEM_BE_EN
    chk("lat3_be", {28'd0, last_be[2]}, 32'h8);
    chk("lat3_wdata", last_wr[2], 32'hABAB_ABAB);
`else
    chk("lat3_wdata", last_wr[2], 32'hAB22_3344);
    chk("lat3_done_lat", done_age[2], 6);
`endif

    // back-to-back SW with valid held across busy cycles: exactly two writes
    for (int i = 0; i < 3; i++) wc[i] = wr_cnt[i];
    issue(32'h10, 32'hCAFE_F00D, 2'b10, 32'h0, 4);
    chk("b2b_wr_count", wr_cnt[0] - wc[0], 2);

    for (int k = 0; k < NV; k++) issue(t_addr[k], t_data[k], t_size[k], t_word[k], 1);

    // reset while the sub-word store sits in WAIT
    @(negedge clk);
    mem_word = 32'h1122_3344; req_addr = 32'h41; req_data = 32'hAB; req_size = 2'b00;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_chk("reset_mid_rmw");
    for (int i = 0; i < 3; i++) wc[i] = wr_cnt[i];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("no_wr_after_reset", wr_cnt[i] - wc[i], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
